seven_segment_scan_decoder: RTL and testbench
=============================================

# seven_segment_scan_decoder

Receive-side counterpart of the binary-to-seven-segment path: watches a time-multiplexed, active-low seven-segment bus and recovers the binary hex value shown on each digit. It filters ghosting during anode changes and assembles a full frame of digits, then publishes the frame with a one-cycle strobe. It sits on the board-test/loopback side, sampling the same segment/anode nets the display driver produces, so the team can self-check displayed values.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (≥2).
- TIMEOUT_CYCLES, 100000, cycles without any accepted digit before Stale asserts (≥STABLE_CYCLES+2).
- Clk  input  1  rising-edge clock; every flop in the block uses this clock.
- Rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of Clk.
- Seven_Segment  input  8  segment bus, active-low; bit0=a … bit6=g, bit7=dp.
- Anode  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
- Value  output  4*NUM_DIGITS  decoded frame; digit i is Value[4i+3:4i].
- Digit_Err  output  NUM_DIGITS  per-digit flag: pattern was not a legal hex glyph.
- Dp  output  NUM_DIGITS  per-digit decimal point, active-high (see Configuration).
- Frame_Valid  output  1  one-cycle strobe: Value/Digit_Err/Dp updated this cycle.
- Stale  output  1  no digit accepted for TIMEOUT_CYCLES.

## Operation
- Input stage: Seven_Segment and Anode registered once (S_seg, S_an); all logic works on registered samples.
- Sample is "single" when exactly one bit of S_an is 0; index of that bit is the sample digit.
- Decode on ~S_seg[6:0] (active-high gfedcba): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F; any other pattern (blank included) → nibble 0, error 1.
- FSM, states SEARCH, QUALIFY, HELD; Count width $clog2(STABLE_CYCLES+1).
  - Any state, sample not single → SEARCH, Count=0.
  - SEARCH, single → QUALIFY, latch (digit, S_seg[6:0]) as candidate, Count=1.
  - QUALIFY, sample equals candidate → Count+1; when Count+1==STABLE_CYCLES, accept and go HELD.
  - QUALIFY or HELD, single but differs from candidate → QUALIFY with new candidate, Count=1.
  - HELD, sample equals candidate → stay; no re-accept.
- Accept: write nibble/error/dp into shadow slot for digit; set Seen[digit].
- Frame: when Seen becomes all ones, next cycle copy shadow to Value/Digit_Err/Dp, pulse Frame_Valid, clear Seen. Re-accepting an already-seen digit overwrites its shadow slot and does not complete the frame.
- Idle counter: cleared on every accept, saturates at TIMEOUT_CYCLES; on reaching it, Stale=1 and Seen cleared. Stale clears on the next accept.
- Reset (Rst_n=0 at an edge): state SEARCH, Count 0, Seen 0, shadow 0, idle counter 0; outputs Value=0, Digit_Err=0, Dp=0, Frame_Valid=0, Stale=0. Reset mid-qualification or mid-frame discards partial data; no Frame_Valid is produced from pre-reset samples.

## Timing
- Digit accepted on the edge where the STABLE_CYCLES-th consecutive identical registered sample is seen: STABLE_CYCLES+1 edges after the first pin sample is presented (1 input register + STABLE_CYCLES).
- Frame_Valid one cycle after the accept that completes the frame; outputs hold until the next Frame_Valid.
- Accept and Stale threshold in the same cycle: accept wins, Stale stays/returns 0.
- Digit glitch shorter than STABLE_CYCLES never produces an accept.
- Anode all-high or multiple-low for any length only resets qualification; Seen is retained.

## Configuration
- SEVEN_SEG_DECODE_DP_EN defined: ~S_seg[7] is part of the candidate match and captured into Dp[i].
- Undefined: bit7 ignored for matching and capture; Dp tied to all zeros.

## Test plan
- NUM_DIGITS=4, STABLE_CYCLES=4: drive Anode=1110/1101/1011/0111 with Seven_Segment=C0/F9/A4/B0, 6 cycles each → single Frame_Valid, Value=16'h3210, Digit_Err=0.
- Digit 2 pattern FF (blank) in an otherwise legal frame → Value[11:8]=0, Digit_Err=4'b0100.
- 3-cycle glitch Anode=1110 with 8'h80 inside digit-0 window of C0 → accepted value 0 only, no error, no extra accept.
- Anode=1100 for 20 cycles between digits → no accepts, frame completes normally after resumption with Seen preserved.
- No Anode activity for TIMEOUT_CYCLES=100 → Stale=1 at cycle 100 after last accept; next accept → Stale=0; partial frame discarded (needs all 4 digits again).
- Rst_n low for 1 cycle after digits 0–2 accepted → all outputs 0; digit 3 alone gives no Frame_Valid. With SEVEN_SEG_DECODE_DP_EN, digit 1 at 8'h79 → Dp=4'b0010, Value[7:4]=1.

Source files
------------

// File: rtl/seven_segment_scan_decoder_if.sv
// Bundle of the multiplexed seven-segment bus and the recovered frame.
// master: drives the segment/anode nets (display side or bench).
// slave : the scan decoder, which samples the bus and reports the frame.
interface seven_segment_scan_decoder_if #(
   parameter int NUM_DIGITS = 4
);
   logic [7:0]              seven_segment;
   logic [NUM_DIGITS-1:0]   anode;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic [NUM_DIGITS-1:0]   dp;
   logic                    frame_valid;
   logic                    stale;

   modport master (
      output seven_segment, anode,
      input  value, digit_err, dp, frame_valid, stale
   );

   modport slave (
      input  seven_segment, anode,
      output value, digit_err, dp, frame_valid, stale
   );
endinterface

// File: rtl/seven_segment_scan_decoder.sv
// Seven-segment scan decoder: samples an active-low, time-multiplexed
// segment/anode bus, qualifies each digit over STABLE_CYCLES identical
// samples, decodes it to a hex nibble and publishes a full frame with a
// one-cycle strobe. Stale flags a bus with no accepted digit for
// TIMEOUT_CYCLES.
// Optional feature macro: SEVEN_SEG_DECODE_DP_EN -- when defined, the
// decimal point takes part in digit matching and is reported per digit;
// otherwise segment bit 7 is ignored and dp is tied low.
module seven_segment_scan_decoder #(
   parameter int NUM_DIGITS     = 4,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic                          clk_i,
   input logic                          rst_n_i,
   seven_segment_scan_decoder_if.slave  scan_io
);

   localparam int DIG_W  = $clog2(NUM_DIGITS);
   localparam int ZC_W   = $clog2(NUM_DIGITS + 1);
   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef SEVEN_SEG_DECODE_DP_EN
   localparam int PAT_W  = 8;
`else
   localparam int PAT_W  = 7;
`endif

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      QUALIFY = 2'd1,
      HELD    = 2'd2
   } state_e;

   // Active-high gfedcba glyph to {error, nibble}; anything unknown is an error.
   function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h3F:   res = 5'h00;
         7'h06:   res = 5'h01;
         7'h5B:   res = 5'h02;
         7'h4F:   res = 5'h03;
         7'h66:   res = 5'h04;
         7'h6D:   res = 5'h05;
         7'h7D:   res = 5'h06;
         7'h07:   res = 5'h07;
         7'h7F:   res = 5'h08;
         7'h6F:   res = 5'h09;
         7'h77:   res = 5'h0A;
         7'h7C:   res = 5'h0B;
         7'h39:   res = 5'h0C;
         7'h5E:   res = 5'h0D;
         7'h79:   res = 5'h0E;
         7'h71:   res = 5'h0F;
         default: res = 5'h10;
      endcase
      return res;
   endfunction

   logic [PAT_W-1:0]        s_pat_q;   // registered segments, active-high
   logic [NUM_DIGITS-1:0]   s_an_q;
   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d, count_inc_s;
   logic [DIG_W-1:0]        cand_digit_q, cand_digit_d;
   logic [PAT_W-1:0]        cand_pat_q, cand_pat_d;
   logic [ZC_W-1:0]         zeros_s;
   logic [DIG_W-1:0]        samp_digit_s;
   logic                    single_s, match_s, accept_s;
   logic [4:0]              decoded_s;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, value_q;
   logic [NUM_DIGITS-1:0]   shadow_err_q, err_q;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic [IDLE_W-1:0]       idle_q, idle_d, idle_inc_s;
   logic                    stale_q, stale_d;
   logic                    frame_valid_q, frame_done_s, timeout_hit_s;

   // Input stage: capture the raw bus once so every decision sees one coherent sample.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s_pat_q <= {PAT_W{1'b0}};
         s_an_q  <= {NUM_DIGITS{1'b1}};
      end else begin
         s_pat_q <= ~scan_io.seven_segment[PAT_W-1:0];
         s_an_q  <= scan_io.anode;
      end
   end

   // Count driven anodes; the last low anode is the digit when exactly one is low.
   always_comb begin
      zeros_s      = {ZC_W{1'b0}};
      samp_digit_s = {DIG_W{1'b0}};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!s_an_q[i]) begin
            zeros_s      = zeros_s + ZC_W'(1);
            samp_digit_s = DIG_W'(i);
         end else begin
            zeros_s      = zeros_s;
         end
      end
   end

   assign single_s    = (zeros_s == ZC_W'(1));
   assign match_s     = single_s && (samp_digit_s == cand_digit_q) && (s_pat_q == cand_pat_q);
   assign count_inc_s = count_q + CNT_W'(1);

   // Qualification state register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= SEARCH;
         count_q      <= {CNT_W{1'b0}};
         cand_digit_q <= {DIG_W{1'b0}};
         cand_pat_q   <= {PAT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cand_digit_q <= cand_digit_d;
         cand_pat_q   <= cand_pat_d;
      end
   end

   // Next state: ghosting (no/multiple anodes) restarts, a new pattern re-arms, a steady one accepts once.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      cand_digit_d = cand_digit_q;
      cand_pat_d   = cand_pat_q;
      accept_s     = 1'b0;
      if (!single_s) begin
         state_d = SEARCH;
         count_d = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            SEARCH: begin
               state_d      = QUALIFY;
               cand_digit_d = samp_digit_s;
               cand_pat_d   = s_pat_q;
               count_d      = CNT_W'(1);
            end
            QUALIFY, HELD: begin
               if (!match_s) begin
                  state_d      = QUALIFY;
                  cand_digit_d = samp_digit_s;
                  cand_pat_d   = s_pat_q;
                  count_d      = CNT_W'(1);
               end else if (state_q == QUALIFY) begin
                  count_d = count_inc_s;
                  if (count_inc_s == CNT_W'(STABLE_CYCLES)) begin
                     accept_s = 1'b1;
                     state_d  = HELD;
                  end else begin
                     state_d  = QUALIFY;
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: begin
               state_d = SEARCH;
               count_d = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign decoded_s     = decode_glyph(cand_pat_q[6:0]);
   assign frame_done_s  = &seen_q;
   assign idle_inc_s    = idle_q + IDLE_W'(1);
   assign timeout_hit_s = !accept_s && (idle_q != IDLE_W'(TIMEOUT_CYCLES))
                          && (idle_inc_s == IDLE_W'(TIMEOUT_CYCLES));

   // Frame bookkeeping and idle timer; an accept beats a coincident timeout.
   always_comb begin
      if (frame_done_s || timeout_hit_s) begin
         seen_d = {NUM_DIGITS{1'b0}};
      end else begin
         seen_d = seen_q;
      end
      if (accept_s) begin
         seen_d[cand_digit_q] = 1'b1;
         idle_d  = {IDLE_W{1'b0}};
         stale_d = 1'b0;
      end else if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) begin
         idle_d  = idle_inc_s;
         stale_d = stale_q | timeout_hit_s;
      end else begin
         idle_d  = idle_q;
         stale_d = stale_q;
      end
   end

   // Shadow slots collect accepted digits; a full frame is copied to the outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shadow_val_q  <= {(4*NUM_DIGITS){1'b0}};
         shadow_err_q  <= {NUM_DIGITS{1'b0}};
         seen_q        <= {NUM_DIGITS{1'b0}};
         idle_q        <= {IDLE_W{1'b0}};
         stale_q       <= 1'b0;
         value_q       <= {(4*NUM_DIGITS){1'b0}};
         err_q         <= {NUM_DIGITS{1'b0}};
         frame_valid_q <= 1'b0;
      end else begin
         if (accept_s) begin
            shadow_val_q[{cand_digit_q, 2'b00} +: 4] <= decoded_s[3:0];
            shadow_err_q[cand_digit_q]               <= decoded_s[4];
         end
         if (frame_done_s) begin
            value_q <= shadow_val_q;
            err_q   <= shadow_err_q;
         end
         seen_q        <= seen_d;
         idle_q        <= idle_d;
         stale_q       <= stale_d;
         frame_valid_q <= frame_done_s;
      end
   end

`ifdef SEVEN_SEG_DECODE_DP_EN
   logic [NUM_DIGITS-1:0] shadow_dp_q, dp_q;

   // Decimal point travels with its digit exactly like the nibble.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         shadow_dp_q <= {NUM_DIGITS{1'b0}};
         dp_q        <= {NUM_DIGITS{1'b0}};
      end else begin
         if (accept_s) begin
            shadow_dp_q[cand_digit_q] <= cand_pat_q[7];
         end
         if (frame_done_s) begin
            dp_q <= shadow_dp_q;
         end
      end
   end

   assign scan_io.dp = dp_q;
`else
   assign scan_io.dp = {NUM_DIGITS{1'b0}};
`endif

   assign scan_io.value       = value_q;
   assign scan_io.digit_err   = err_q;
   assign scan_io.frame_valid = frame_valid_q;
   assign scan_io.stale       = stale_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Self-checking bench for seven_segment_scan_decoder (4 digits, 4-sample
// qualification, 100-cycle timeout). A run-length reference model derived
// from the bus rules predicts every output on every cycle; each scenario
// also checks its headline result against fixed values.
module tb_seven_segment_scan_decoder;

   localparam int ND      = 4;
   localparam int STABLE  = 4;
   localparam int TIMEOUT = 100;
   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   typedef struct { logic [3:0] an; logic [7:0] seg; int len; } seg_t;

   logic clk, rst_n;
   seven_segment_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

   seven_segment_scan_decoder #(
      .NUM_DIGITS(ND), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .scan_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   // reference model state
   logic [15:0] m_val, sh_val;
   logic [3:0]  m_err, sh_err, m_dp, sh_dp, seen;
   logic        m_fv, m_stale;
   int          idle, run_len, run_dig;
   logic [7:0]  run_key;
   logic [3:0]  reg_an;
   logic [7:0]  reg_seg;
   logic [25:0] exp_v;
   wire  [25:0] obs_v = {bus.value, bus.digit_err, bus.dp, bus.frame_valid, bus.stale};

   task automatic model_reset();
      m_val = '0; sh_val = '0; m_err = '0; sh_err = '0; m_dp = '0; sh_dp = '0; seen = '0;
      m_fv = 1'b0; m_stale = 1'b0; idle = 0; run_len = 0; run_dig = 0; run_key = '0;
      reg_an = 4'hF; reg_seg = 8'hFF;
      exp_v = '0;
   endtask

   // One clock edge of the display-observer behaviour, on the previously registered sample.
   task automatic model_edge(input logic [3:0] pin_an, input logic [7:0] pin_seg);
      logic full, acc, tmo, err;
      int z, d, nib;
      logic [7:0] key;
      full = (seen == 4'hF);
      m_fv = full;
      if (full) begin m_val = sh_val; m_err = sh_err; m_dp = sh_dp; end
      z = 0; d = 0;
      for (int i = 0; i < ND; i++) if (!reg_an[i]) begin z++; d = i; end
`ifdef SEVEN_SEG_DECODE_DP_EN
      key = ~reg_seg;
`else
      key = {1'b0, ~reg_seg[6:0]};
`endif
      if (z != 1) run_len = 0;
      else if (run_len > 0 && d == run_dig && key == run_key) run_len++;
      else begin run_len = 1; run_dig = d; run_key = key; end
      acc = (run_len == STABLE);
      tmo = !acc && (idle < TIMEOUT) && (idle + 1 == TIMEOUT);
      if (full || tmo) seen = '0;
      if (acc) begin
         nib = 0; err = 1'b1;
         for (int g = 0; g < 16; g++) if (key[6:0] == GLYPH[g]) begin nib = g; err = 1'b0; end
         sh_val[4*d +: 4] = 4'(nib);
         sh_err[d] = err;
         sh_dp[d]  = key[7];
         seen[d]   = 1'b1;
         idle = 0; m_stale = 1'b0;
      end else if (idle < TIMEOUT) begin
         idle++;
         if (idle == TIMEOUT) m_stale = 1'b1;
      end
      reg_an = pin_an; reg_seg = pin_seg;
      exp_v = {m_val, m_err, m_dp, m_fv, m_stale};
   endtask

   // Drive one cycle of bus pins (and reset), then advance the model past the edge.
   task automatic step(input logic [3:0] an, input logic [7:0] seg, input logic rst);
      bus.anode = an; bus.seven_segment = seg; rst_n = ~rst;
      @(posedge clk); #1;
      if (rst) model_reset(); else model_edge(an, seg);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) step(4'hF, 8'hFF, 1'b1);
      n_chk++;
      if (obs_v !== 26'd0 || obs_v !== exp_v) begin
         n_fail++; $display("FAIL reset_state got=%h want=%h", obs_v, 26'd0);
      end
   endtask

   task automatic test_frame(input logic [7:0] s2, input logic [15:0] want_val, input logic [3:0] want_err);
      seg_t q[$];
      int n_fv = 0;
      q = '{'{4'hE, 8'hC0, 6}, '{4'hD, 8'hF9, 6}, '{4'hB, s2, 6}, '{4'h7, 8'hB0, 6}, '{4'hF, 8'hFF, 3}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL frame_cycle got=%h want=%h", obs_v, exp_v); end
         if (bus.frame_valid === 1'b1) n_fv++;
      end
      n_chk++;
      if (n_fv != 1 || bus.value !== want_val || bus.digit_err !== want_err) begin
         n_fail++;
         $display("FAIL frame_result got fv=%0d val=%h err=%b want fv=1 val=%h err=%b",
                  n_fv, bus.value, bus.digit_err, want_val, want_err);
      end
   endtask

   task automatic test_glitch();
      seg_t q[$];
      int n_fv = 0;
      q = '{'{4'hE, 8'hC0, 2}, '{4'hE, 8'h80, 3}, '{4'hE, 8'hC0, 6}, '{4'hD, 8'hF9, 6},
            '{4'hB, 8'hA4, 6}, '{4'h7, 8'hB0, 6}, '{4'hF, 8'hFF, 3}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL glitch_cycle got=%h want=%h", obs_v, exp_v); end
         if (bus.frame_valid === 1'b1) n_fv++;
      end
      n_chk++;
      if (n_fv != 1 || bus.value !== 16'h3210 || bus.digit_err !== 4'b0000) begin
         n_fail++; $display("FAIL glitch_result got fv=%0d val=%h err=%b want fv=1 val=3210 err=0000",
                            n_fv, bus.value, bus.digit_err);
      end
   endtask

   task automatic test_ghost();
      seg_t q[$];
      int n_fv = 0;
      q = '{'{4'hE, 8'hC0, 6}, '{4'hD, 8'hF9, 6}, '{4'hC, 8'hC0, 20}, '{4'hB, 8'hA4, 6},
            '{4'h7, 8'hB0, 6}, '{4'hF, 8'hFF, 3}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL ghost_cycle got=%h want=%h", obs_v, exp_v); end
         if (bus.frame_valid === 1'b1) n_fv++;
      end
      n_chk++;
      if (n_fv != 1 || bus.value !== 16'h3210) begin
         n_fail++; $display("FAIL ghost_result got fv=%0d val=%h want fv=1 val=3210", n_fv, bus.value);
      end
   endtask

   task automatic test_timeout();
      seg_t q[$];
      int n_fv = 0, first_stale = -1, idx = 0;
      // digit 0 is accepted on cycle 4; stale must first show 100 cycles later (cycle 104)
      q = '{'{4'hE, 8'hC0, 6}, '{4'hF, 8'hFF, 110}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL timeout_cycle got=%h want=%h", obs_v, exp_v); end
         if (bus.stale === 1'b1 && first_stale < 0) first_stale = idx;
         idx++;
      end
      n_chk++;
      if (first_stale != 104) begin
         n_fail++; $display("FAIL stale_onset got=%0d want=104", first_stale);
      end
      q = '{'{4'hD, 8'hF9, 6}, '{4'hB, 8'hA4, 6}, '{4'h7, 8'hB0, 6}, '{4'hF, 8'hFF, 3}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL partial_cycle got=%h want=%h", obs_v, exp_v); end
         if (bus.frame_valid === 1'b1) n_fv++;
      end
      n_chk++;
      if (n_fv != 0 || bus.stale !== 1'b0) begin
         n_fail++; $display("FAIL stale_discard got fv=%0d stale=%b want fv=0 stale=0", n_fv, bus.stale);
      end
   endtask

   task automatic test_reset_mid();
      seg_t q[$];
      int n_fv = 0;
      q = '{'{4'hE, 8'hC0, 6}, '{4'hD, 8'hF9, 6}, '{4'hB, 8'hA4, 6}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) step(q[k].an, q[k].seg, 1'b0);
      step(4'hF, 8'hFF, 1'b1);
      n_chk++;
      if (obs_v !== 26'd0) begin n_fail++; $display("FAIL reset_mid got=%h want=0", obs_v); end
      q = '{'{4'h7, 8'hB0, 6}, '{4'hF, 8'hFF, 4}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL postreset_cycle got=%h want=%h", obs_v, exp_v); end
         if (bus.frame_valid === 1'b1) n_fv++;
      end
      n_chk++;
      if (n_fv != 0) begin n_fail++; $display("FAIL postreset_frame got fv=%0d want=0", n_fv); end
   endtask

`ifdef SEVEN_SEG_DECODE_DP_EN
   task automatic test_dp();
      seg_t q[$];
      q = '{'{4'hE, 8'hC0, 6}, '{4'hD, 8'h79, 6}, '{4'hB, 8'hA4, 6}, '{4'h7, 8'hB0, 6}, '{4'hF, 8'hFF, 3}};
      foreach (q[k]) for (int c = 0; c < q[k].len; c++) begin
         step(q[k].an, q[k].seg, 1'b0);
         n_chk++;
         if (obs_v !== exp_v) begin n_fail++; $display("FAIL dp_cycle got=%h want=%h", obs_v, exp_v); end
      end
      n_chk++;
      if (bus.dp !== 4'b0010 || bus.value[7:4] !== 4'h1) begin
         n_fail++; $display("FAIL dp_result got dp=%b v=%h want dp=0010 v=1", bus.dp, bus.value[7:4]);
      end
   endtask
`endif

   task automatic test_random();
      logic [3:0] an;
      logic [7:0] seg;
      int len;
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 9) < 7) an = ~(4'b0001 << $urandom_range(0, 3));
         else an = 4'($urandom);
         if ($urandom_range(0, 9) < 7) seg = ~{1'($urandom), GLYPH[$urandom_range(0, 15)]};
         else seg = 8'($urandom);
         len = $urandom_range(1, 7);
         for (int c = 0; c < len; c++) begin
            step(an, seg, 1'b0);
            n_chk++;
            if (obs_v !== exp_v) begin
               n_fail++; $display("FAIL random_cycle an=%b seg=%h got=%h want=%h", an, seg, obs_v, exp_v);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      bus.anode = 4'hF; bus.seven_segment = 8'hFF; rst_n = 1'b0;
      test_reset();
      test_frame(8'hA4, 16'h3210, 4'b0000);
      test_frame(8'hFF, 16'h3010, 4'b0100);
      test_glitch();
      test_ghost();
      test_timeout();
      test_reset_mid();
`ifdef SEVEN_SEG_DECODE_DP_EN
      test_dp();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
